// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline-stage observations in, latch/PC controls and
// stall statistics out. The pipeline (master) drives observations; the hazard unit is the slave.
interface hazard_unit_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] rsID;
    logic [REG_W-1:0] rtID;
    logic             useRtID;
    logic [REG_W-1:0] destEX;
    logic             memReadEX;
    logic             dRENMEM;
    logic             dWENMEM;
    logic             dhit;
    logic             ihit;
    logic             redirMEM;

    logic             pcEN;
    logic             ifidEN;
    logic             ifidFLUSH;
    logic             idexEN;
    logic             idexFLUSH;
    logic             exmemEN;
    logic             exmemFLUSH;
    logic             memwbEN;
    logic [1:0]       hzState;
    logic [CNT_W-1:0] luCount;
    logic [CNT_W-1:0] dwCount;
    logic [CNT_W-1:0] rdCount;

    modport master (
        output rsID, rtID, useRtID, destEX, memReadEX, dRENMEM, dWENMEM, dhit, ihit, redirMEM,
        input  pcEN, ifidEN, ifidFLUSH, idexEN, idexFLUSH, exmemEN, exmemFLUSH, memwbEN,
        input  hzState, luCount, dwCount, rdCount
    );

    modport slave (
        input  rsID, rtID, useRtID, destEX, memReadEX, dRENMEM, dWENMEM, dhit, ihit, redirMEM,
        output pcEN, ifidEN, ifidFLUSH, idexEN, idexFLUSH, exmemEN, exmemFLUSH, memwbEN,
        output hzState, luCount, dwCount, rdCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: load-use stalls, data-memory freezes,
// fetch-miss bubbles and branch/jump redirect flushes, plus saturating per-cause counters.
module hazard_unit (
    input  logic          CLK,
    input  logic          nRST,
    hazard_unit_if.slave  hif
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LUSTALL = 2'd1,
        DWAIT   = 2'd2,
        REDIR   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   dwait;
    logic   lu;

    assign dwait = (hif.dRENMEM | hif.dWENMEM) & ~hif.dhit;
    assign lu    = hif.memReadEX & (hif.destEX != '0) &
                   ((hif.destEX == hif.rsID) | (hif.useRtID & (hif.destEX == hif.rtID)));

    // next_state doubles as the "action taken this cycle" tag that drives the counters.
    always_comb begin
        next_state     = RUN;
        hif.pcEN       = 1'b0;
        hif.ifidEN     = 1'b0;
        hif.ifidFLUSH  = 1'b0;
        hif.idexEN     = 1'b0;
        hif.idexFLUSH  = 1'b0;
        hif.exmemEN    = 1'b0;
        hif.exmemFLUSH = 1'b0;
        hif.memwbEN    = 1'b0;
        if (dwait) begin
            next_state = DWAIT;
        end else if (hif.redirMEM) begin
            next_state     = REDIR;
            hif.pcEN       = 1'b1;
            hif.ifidEN     = 1'b1;
            hif.ifidFLUSH  = 1'b1;
            hif.idexEN     = 1'b1;
            hif.idexFLUSH  = 1'b1;
            hif.exmemEN    = 1'b1;
            hif.exmemFLUSH = 1'b1;
            hif.memwbEN    = 1'b1;
        end else if (lu) begin
            next_state    = LUSTALL;
            hif.idexEN    = 1'b1;
            hif.idexFLUSH = 1'b1;
            hif.exmemEN   = 1'b1;
            hif.memwbEN   = 1'b1;
        end else if (!hif.ihit) begin
            hif.ifidEN    = 1'b1;
            hif.ifidFLUSH = 1'b1;
            hif.idexEN    = 1'b1;
            hif.exmemEN   = 1'b1;
            hif.memwbEN   = 1'b1;
        end else begin
            hif.pcEN    = 1'b1;
            hif.ifidEN  = 1'b1;
            hif.idexEN  = 1'b1;
            hif.exmemEN = 1'b1;
            hif.memwbEN = 1'b1;
        end
        // Hold every latch while reset is asserted, regardless of the inputs.
        if (!nRST) begin
            hif.pcEN       = 1'b0;
            hif.ifidEN     = 1'b0;
            hif.ifidFLUSH  = 1'b0;
            hif.idexEN     = 1'b0;
            hif.idexFLUSH  = 1'b0;
            hif.exmemEN    = 1'b0;
            hif.exmemFLUSH = 1'b0;
            hif.memwbEN    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            hif.luCount <= '0;
            hif.dwCount <= '0;
            hif.rdCount <= '0;
        end else begin
            state <= next_state;
            if (next_state == LUSTALL && hif.luCount != '1)
                hif.luCount <= hif.luCount + 1'b1;
            if (next_state == DWAIT && hif.dwCount != '1)
                hif.dwCount <= hif.dwCount + 1'b1;
            if (next_state == REDIR && hif.rdCount != '1)
                hif.rdCount <= hif.rdCount + 1'b1;
        end
    end

    assign hif.hzState = state;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand-written reset/saturation sequences,
// and random stimulus against a rule-level model; a 4-bit-counter twin covers saturation.
module tb_hazard_unit;
    logic clk;
    logic rst_n;

    hazard_unit_if #(.REG_W(5), .CNT_W(16)) hif ();
    hazard_unit_if #(.REG_W(5), .CNT_W(4))  hif4 ();

    hazard_unit dut  (.CLK(clk), .nRST(rst_n), .hif(hif));
    hazard_unit dut4 (.CLK(clk), .nRST(rst_n), .hif(hif4));

    assign hif4.rsID      = hif.rsID;
    assign hif4.rtID      = hif.rtID;
    assign hif4.useRtID   = hif.useRtID;
    assign hif4.destEX    = hif.destEX;
    assign hif4.memReadEX = hif.memReadEX;
    assign hif4.dRENMEM   = hif.dRENMEM;
    assign hif4.dWENMEM   = hif.dWENMEM;
    assign hif4.dhit      = hif.dhit;
    assign hif4.ihit      = hif.ihit;
    assign hif4.redirMEM  = hif.redirMEM;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, dest;
        logic       use_rt, mem_read, dren, dwen, dhit, ihit, redir;
        logic [7:0] ctrl;   // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en}
        logic [1:0] st;
    } vec_t;

    localparam logic [7:0] C_NORM = 8'b1101_0101;
    localparam logic [7:0] C_FRZ  = 8'b0000_0000;
    localparam logic [7:0] C_RDR  = 8'b1111_1111;
    localparam logic [7:0] C_LU   = 8'b0001_1101;
    localparam logic [7:0] C_MISS = 8'b0111_0101;

    int n_pass = 0;
    int n_total = 0;
    int lu_n, dw_n, rd_n, st_m;

    function automatic vec_t mk(input int rs, input int rt, input int dest, input bit use_rt,
                                input bit mem_read, input bit dren, input bit dwen, input bit dhit,
                                input bit ihit, input bit redir, input logic [7:0] ctrl, input int st);
        vec_t v;
        v.rs = rs[4:0]; v.rt = rt[4:0]; v.dest = dest[4:0];
        v.use_rt = use_rt; v.mem_read = mem_read; v.dren = dren; v.dwen = dwen;
        v.dhit = dhit; v.ihit = ihit; v.redir = redir; v.ctrl = ctrl; v.st = st[1:0];
        return v;
    endfunction

    // Action code of the rules: 0 run/miss, 1 load-use, 2 dmem wait, 3 redirect.
    function automatic int cause(input vec_t v);
        bit waiting = (v.dren || v.dwen) && !v.dhit;
        bit hazard  = v.mem_read && v.dest != 0 &&
                      (v.dest == v.rs || (v.use_rt && v.dest == v.rt));
        if (waiting) return 2;
        if (v.redir) return 3;
        if (hazard)  return 1;
        return 0;
    endfunction

    function automatic logic [7:0] model_ctrl(input vec_t v);
        case (cause(v))
            2:       return C_FRZ;
            3:       return C_RDR;
            1:       return C_LU;
            default: return v.ihit ? C_NORM : C_MISS;
        endcase
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {hif.pcEN, hif.ifidEN, hif.ifidFLUSH, hif.idexEN, hif.idexFLUSH,
                hif.exmemEN, hif.exmemFLUSH, hif.memwbEN};
    endfunction

    function automatic logic [7:0] dut4_ctrl();
        return {hif4.pcEN, hif4.ifidEN, hif4.ifidFLUSH, hif4.idexEN, hif4.idexFLUSH,
                hif4.exmemEN, hif4.exmemFLUSH, hif4.memwbEN};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_counters(input string name);
        check({name, " luCount"},  int'(hif.luCount),  sat(lu_n, 65535));
        check({name, " dwCount"},  int'(hif.dwCount),  sat(dw_n, 65535));
        check({name, " rdCount"},  int'(hif.rdCount),  sat(rd_n, 65535));
        check({name, " luCount4"}, int'(hif4.luCount), sat(lu_n, 15));
        check({name, " dwCount4"}, int'(hif4.dwCount), sat(dw_n, 15));
        check({name, " rdCount4"}, int'(hif4.rdCount), sat(rd_n, 15));
    endtask

    task automatic drive(input vec_t v);
        hif.rsID = v.rs; hif.rtID = v.rt; hif.destEX = v.dest; hif.useRtID = v.use_rt;
        hif.memReadEX = v.mem_read; hif.dRENMEM = v.dren; hif.dWENMEM = v.dwen;
        hif.dhit = v.dhit; hif.ihit = v.ihit; hif.redirMEM = v.redir;
    endtask

    // Called at posedge+2; checks controls mid-cycle, then state/counters after the edge.
    task automatic step(input vec_t v, input bit tbl, input string name);
        int c;
        drive(v);
        #1;
        c = cause(v);
        check({name, " ctrl"}, int'(dut_ctrl()), int'(model_ctrl(v)));
        if (tbl) check({name, " ctrl_tbl"}, int'(dut_ctrl()), int'(v.ctrl));
        @(posedge clk);
        #2;
        st_m = c;
        if (c == 1) lu_n++;
        if (c == 2) dw_n++;
        if (c == 3) rd_n++;
        check({name, " hzState"}, int'(hif.hzState), st_m);
        if (tbl) check({name, " hzState_tbl"}, int'(hif.hzState), int'(v.st));
        check_counters(name);
    endtask

    task automatic check_reset(input string name);
        check({name, " ctrl"},    int'(dut_ctrl()),  0);
        check({name, " ctrl4"},   int'(dut4_ctrl()), 0);
        check({name, " hzState"}, int'(hif.hzState), 0);
        check_counters(name);
    endtask

    vec_t tbl[$];
    vec_t idle, v;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_NORM, 0);
        lu_n = 0; dw_n = 0; rd_n = 0; st_m = 0;
        rst_n = 1'b0;
        drive(idle);
        #12;
        check_reset("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        //            rs rt dst urt mrd drn dwn dht iht rdr  ctrl    st
        tbl.push_back(mk(2, 0, 2, 0, 1, 0, 0, 1, 1, 0, C_LU,   1));  // T1 load-use on rs
        tbl.push_back(mk(2, 0, 2, 0, 0, 0, 0, 1, 1, 0, C_NORM, 0));  // bubble clears it
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, C_NORM, 0));  // T2 dest r0
        tbl.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, 1, 0, C_NORM, 0));  // T2 rt match, rt unused
        tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, 1, 1, 0, C_LU,   1));  // rt match, rt used
        tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, 1, 1, 0, C_LU,   1));  // restall from LUSTALL
        tbl.push_back(idle);
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_FRZ,  2));  // T3 dmem wait x3
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_FRZ,  2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_FRZ,  2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, C_NORM, 0));
        tbl.push_back(mk(3, 0, 3, 0, 1, 0, 0, 1, 1, 1, C_RDR,  3));  // T4 redirect beats lu
        tbl.push_back(idle);
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, C_FRZ,  2));  // T5 freeze beats redirect
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, C_FRZ,  2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, C_RDR,  3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MISS, 0));  // fetch miss
        tbl.push_back(mk(4, 0, 4, 0, 1, 0, 0, 1, 0, 0, C_LU,   1));  // lu beats miss
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_RDR,  3));  // redirect beats miss
        tbl.push_back(mk(6, 0, 6, 0, 1, 1, 0, 0, 0, 0, C_FRZ,  2));  // freeze beats lu and miss
        tbl.push_back(idle);
        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Twenty back-to-back load-use cycles push the 4-bit twin into saturation.
        v = mk(7, 0, 7, 0, 1, 0, 0, 1, 1, 0, C_LU, 1);
        for (int i = 0; i < 20; i++) step(v, 1'b0, "lu_sat");
        check("lu_sat luCount4 max", int'(hif4.luCount), 15);
        step(idle, 1'b0, "lu_sat_exit");

        // Reset asserted mid-cycle during a dmem wait takes effect without a clock edge.
        v = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_FRZ, 2);
        step(v, 1'b0, "dw_pre");
        step(v, 1'b0, "dw_pre");
        v = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, C_NORM, 0);
        drive(v);
        #1;
        rst_n = 1'b0;
        #1;
        lu_n = 0; dw_n = 0; rd_n = 0; st_m = 0;
        check_reset("async_reset");
        @(posedge clk);
        #2;
        check_reset("reset_held");
        rst_n = 1'b1;
        step(idle, 1'b0, "post_reset");

        for (int i = 0; i < 400; i++) begin
            v.rs       = 5'($urandom_range(0, 3));
            v.rt       = 5'($urandom_range(0, 3));
            v.dest     = 5'($urandom_range(0, 3));
            v.use_rt   = 1'($urandom_range(0, 1));
            v.mem_read = 1'($urandom_range(0, 1));
            v.dren     = ($urandom_range(0, 3) == 0);
            v.dwen     = ($urandom_range(0, 3) == 0);
            v.dhit     = ($urandom_range(0, 3) != 0);
            v.ihit     = ($urandom_range(0, 3) != 0);
            v.redir    = ($urandom_range(0, 7) == 0);
            step(v, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
